// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch prediction and execute resolve bundle for branch_predict_unit
interface branch_predict_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DISP_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0] fetchPc;
    logic [ADDR_WIDTH-1:0] predPc;
    logic                  predTaken;
    logic                  resValid;
    logic [ADDR_WIDTH-1:0] resPc;
    logic [2:0]            resBrCode;
    logic [DATA_WIDTH-1:0] resRegRS;
    logic [DATA_WIDTH-1:0] resRegRT;
    logic [DISP_WIDTH-1:0] resConstant;
    logic [ADDR_WIDTH-1:0] resPredPc;
    logic                  redirectValid;
    logic [ADDR_WIDTH-1:0] redirectPc;
    logic                  resTaken;
    logic [CNT_WIDTH-1:0]  branchCount;
    logic [CNT_WIDTH-1:0]  mispredictCount;

    modport master (
        output fetchPc, resValid, resPc, resBrCode, resRegRS, resRegRT, resConstant, resPredPc,
        input  predPc, predTaken, redirectValid, redirectPc, resTaken, branchCount, mispredictCount
    );

    modport slave (
        input  fetchPc, resValid, resPc, resBrCode, resRegRS, resRegRT, resConstant, resPredPc,
        output predPc, predTaken, redirectValid, redirectPc, resTaken, branchCount, mispredictCount
    );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BHT/BTB next-PC predictor with execute-stage resolve, redirect and statistics
module branch_predict_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DISP_WIDTH  = 16,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    branch_predict_unit_if.slave  bus
);
    localparam int BHT_IDX = $clog2(BHT_ENTRIES);
    localparam int BTB_IDX = $clog2(BTB_ENTRIES);
    localparam int TAG_W   = ADDR_WIDTH - 2 - BTB_IDX;

    localparam logic [2:0] BR_NONE  = 3'd0;
    localparam logic [2:0] BR_EQ    = 3'd1;
    localparam logic [2:0] BR_NE    = 3'd2;
    localparam logic [2:0] BR_TAKEN = 3'd3;
    localparam logic [2:0] BR_LTZ   = 3'd4;
    localparam logic [2:0] BR_GEZ   = 3'd5;

    logic [1:0]            bht_q       [BHT_ENTRIES];
    logic                  btb_valid_q [BTB_ENTRIES];
    logic [TAG_W-1:0]      btb_tag_q   [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] btb_tgt_q   [BTB_ENTRIES];

    logic                  redirect_valid_q, redirect_valid_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                  res_taken_q, res_taken_d;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;

    // Prediction side
    logic [BHT_IDX-1:0] f_bht_idx;
    logic [BTB_IDX-1:0] f_btb_idx;
    logic [TAG_W-1:0]   f_tag;
    logic               f_hit;

    assign f_bht_idx = bus.fetchPc[2 +: BHT_IDX];
    assign f_btb_idx = bus.fetchPc[2 +: BTB_IDX];
    assign f_tag     = bus.fetchPc[ADDR_WIDTH-1 -: TAG_W];
    assign f_hit     = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);

    assign bus.predTaken = f_hit && bht_q[f_bht_idx][1];
    assign bus.predPc    = bus.predTaken ? btb_tgt_q[f_btb_idx] : bus.fetchPc + ADDR_WIDTH'(4);

    // Resolve side
    logic [BHT_IDX-1:0]    r_bht_idx;
    logic [BTB_IDX-1:0]    r_btb_idx;
    logic [TAG_W-1:0]      r_tag;
    logic                  r_hit;
    logic                  accept;
    logic                  is_branch;
    logic                  taken;
    logic                  mispredict;
    logic [ADDR_WIDTH-1:0] disp_ext;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] actual_next;
    logic [1:0]            bht_cur;
    logic [1:0]            bht_d;
    logic                  btb_set;
    logic                  btb_clr;

    assign r_bht_idx = bus.resPc[2 +: BHT_IDX];
    assign r_btb_idx = bus.resPc[2 +: BTB_IDX];
    assign r_tag     = bus.resPc[ADDR_WIDTH-1 -: TAG_W];
    assign r_hit     = btb_valid_q[r_btb_idx] && (btb_tag_q[r_btb_idx] == r_tag);

    // A pending redirect means execute holds a wrong-path instruction.
    assign accept    = bus.resValid && !redirect_valid_q;
    assign is_branch = (bus.resBrCode >= BR_EQ) && (bus.resBrCode <= BR_GEZ);

    always_comb begin
        taken = 1'b0;
        case (bus.resBrCode)
            BR_EQ:    taken = (bus.resRegRS == bus.resRegRT);
            BR_NE:    taken = (bus.resRegRS != bus.resRegRT);
            BR_TAKEN: taken = 1'b1;
            BR_LTZ:   taken = bus.resRegRS[DATA_WIDTH-1];
            BR_GEZ:   taken = !bus.resRegRS[DATA_WIDTH-1];
            default:  taken = 1'b0;
        endcase
    end

    assign disp_ext    = {{(ADDR_WIDTH-DISP_WIDTH){bus.resConstant[DISP_WIDTH-1]}}, bus.resConstant};
    assign pc_plus4    = bus.resPc + ADDR_WIDTH'(4);
    assign target      = pc_plus4 + (disp_ext << 2);
    assign actual_next = taken ? target : pc_plus4;
    assign mispredict  = (actual_next != bus.resPredPc);

    assign bht_cur = bht_q[r_bht_idx];
    always_comb begin
        bht_d = bht_cur;
        if (taken) begin
            if (bht_cur != 2'b11) bht_d = bht_cur + 2'b01;
        end else begin
            if (bht_cur != 2'b00) bht_d = bht_cur - 2'b01;
        end
    end

    assign btb_set = accept && is_branch && taken;
    assign btb_clr = accept && !is_branch && r_hit;

    always_comb begin
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        res_taken_d      = res_taken_q;
        branch_cnt_d     = branch_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;
        if (accept) begin
            redirect_valid_d = mispredict;
            redirect_pc_d    = actual_next;
            res_taken_d      = taken;
            if (is_branch && (branch_cnt_q != {CNT_WIDTH{1'b1}}))
                branch_cnt_d = branch_cnt_q + 1'b1;
            if (mispredict && (mispred_cnt_q != {CNT_WIDTH{1'b1}}))
                mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            res_taken_q      <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            res_taken_q      <= res_taken_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (accept && is_branch) begin
            bht_q[r_bht_idx] <= bht_d;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
        end else if (btb_set) begin
            btb_valid_q[r_btb_idx] <= 1'b1;
        end else if (btb_clr) begin
            btb_valid_q[r_btb_idx] <= 1'b0;
        end
    end

    // Tag/target are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (btb_set) begin
            btb_tag_q[r_btb_idx] <= r_tag;
            btb_tgt_q[r_btb_idx] <= target;
        end
    end

    assign bus.redirectValid   = redirect_valid_q;
    assign bus.redirectPc      = redirect_pc_q;
    assign bus.resTaken        = res_taken_q;
    assign bus.branchCount     = branch_cnt_q;
    assign bus.mispredictCount = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = 16;
    localparam int CW = 4;

    logic clk;
    logic rstN;
    int   total;
    int   bad;

    branch_predict_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DISP_WIDTH(PW), .CNT_WIDTH(CW)) bif ();

    branch_predict_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DISP_WIDTH(PW),
        .BHT_ENTRIES(64), .BTB_ENTRIES(16), .CNT_WIDTH(CW)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [2:0] code, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [15:0] c, input logic [31:0] ppc);
        bif.resValid    = 1'b1;
        bif.resPc       = pc;
        bif.resBrCode   = code;
        bif.resRegRS    = rs;
        bif.resRegRT    = rt;
        bif.resConstant = c;
        bif.resPredPc   = ppc;
        tick();
        bif.resValid    = 1'b0;
    endtask

    task automatic chk_regs(input string tag, input logic rv, input logic [31:0] rpc, input logic rt,
                            input logic [31:0] bc, input logic [31:0] mc);
        chk({tag, "_rv"},  32'(bif.redirectValid), 32'(rv));
        chk({tag, "_rpc"}, bif.redirectPc, rpc);
        chk({tag, "_rt"},  32'(bif.resTaken), 32'(rt));
        chk({tag, "_bc"},  32'(bif.branchCount), bc);
        chk({tag, "_mc"},  32'(bif.mispredictCount), mc);
    endtask

    task automatic chk_pred(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] npc);
        bif.fetchPc = pc;
        #1;
        chk({tag, "_ptk"}, 32'(bif.predTaken), 32'(tk));
        chk({tag, "_ppc"}, bif.predPc, npc);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstN  = 1'b0;
        bif.fetchPc     = 32'h100;
        bif.resValid    = 1'b0;
        bif.resPc       = '0;
        bif.resBrCode   = '0;
        bif.resRegRS    = '0;
        bif.resRegRT    = '0;
        bif.resConstant = '0;
        bif.resPredPc   = '0;
        #13;

        // Reset state
        chk_regs("rst", 1'b0, 32'h0, 1'b0, 0, 0);
        chk_pred("rst", 32'h100, 1'b0, 32'h104);
        #10 rstN = 1'b1;
        tick();
        chk_regs("idle0", 1'b0, 32'h0, 1'b0, 0, 0);

        // First taken EQ, mispredicted as fall-through
        resolve(32'h100, 3'd1, 32'd5, 32'd5, 16'h0003, 32'h104);
        chk_regs("eq1", 1'b1, 32'h110, 1'b1, 1, 1);
        chk_pred("eq1", 32'h100, 1'b1, 32'h110);
        tick();
        chk("eq1_pulse", 32'(bif.redirectValid), 32'd0);

        // Negative displacement, correctly predicted; evicts the aliasing 0x100 BTB entry
        resolve(32'h200, 3'd3, 32'd0, 32'd0, 16'hFFFE, 32'h1FC);
        chk_regs("tk", 1'b0, 32'h1FC, 1'b1, 2, 1);
        chk_pred("tk200", 32'h200, 1'b1, 32'h1FC);
        chk_pred("tk100", 32'h100, 1'b0, 32'h104);

        // Saturation then decay of the 0x100 counter
        for (int i = 0; i < 3; i++) resolve(32'h100, 3'd1, 32'd5, 32'd5, 16'h0003, 32'h110);
        chk_regs("sat", 1'b0, 32'h110, 1'b1, 5, 1);
        chk_pred("sat", 32'h100, 1'b1, 32'h110);
        resolve(32'h100, 3'd2, 32'd7, 32'd7, 16'h0003, 32'h104);
        chk_regs("nt1", 1'b0, 32'h104, 1'b0, 6, 1);
        chk_pred("nt1", 32'h100, 1'b1, 32'h110);
        resolve(32'h100, 3'd2, 32'd7, 32'd7, 16'h0003, 32'h104);
        resolve(32'h100, 3'd2, 32'd7, 32'd7, 16'h0003, 32'h104);
        chk_pred("nt3", 32'h100, 1'b0, 32'h104);

        // Squash: the resolve following a redirect is ignored
        bif.resValid = 1'b1; bif.resPc = 32'h108; bif.resBrCode = 3'd3;
        bif.resConstant = 16'h0001; bif.resPredPc = 32'h10C;
        tick();
        chk_regs("sqN", 1'b1, 32'h110, 1'b1, 9, 2);
        bif.resPc = 32'h10C; bif.resBrCode = 3'd3; bif.resConstant = 16'h0000; bif.resPredPc = 32'h0;
        tick();
        bif.resValid = 1'b0;
        chk_regs("sqN1", 1'b0, 32'h110, 1'b1, 9, 2);
        chk_pred("sqN1", 32'h10C, 1'b0, 32'h110);
        resolve(32'h10C, 3'd3, 32'd0, 32'd0, 16'h0000, 32'h110);
        chk_pred("sqT", 32'h10C, 1'b1, 32'h110);
        resolve(32'h10C, 3'd2, 32'd1, 32'd1, 16'h0000, 32'h110);
        chk_regs("sqNT", 1'b0, 32'h110, 1'b0, 11, 2);
        chk_pred("sqNT", 32'h10C, 1'b0, 32'h110);

        // NONE invalidates a hitting BTB entry and still redirects
        resolve(32'h104, 3'd3, 32'd0, 32'd0, 16'h0002, 32'h110);
        chk_pred("nn_pre", 32'h104, 1'b1, 32'h110);
        resolve(32'h104, 3'd0, 32'd0, 32'd0, 16'h0002, 32'h104);
        chk_regs("none", 1'b1, 32'h108, 1'b0, 12, 3);
        chk_pred("none", 32'h104, 1'b0, 32'h108);
        tick();

        // LTZ taken, GEZ not taken on a negative operand
        resolve(32'h400, 3'd4, 32'h8000_0000, 32'd0, 16'h0004, 32'h414);
        chk_regs("ltz", 1'b0, 32'h414, 1'b1, 13, 3);
        resolve(32'h400, 3'd5, 32'h8000_0000, 32'd0, 16'h0004, 32'h414);
        chk_regs("gez", 1'b1, 32'h404, 1'b0, 14, 4);
        tick();

        // branchCount saturates at all-ones
        for (int i = 0; i < 3; i++) resolve(32'h104, 3'd3, 32'd0, 32'd0, 16'h0002, 32'h110);
        chk("bc_sat", 32'(bif.branchCount), 32'd15);

        // Asynchronous reset while a redirect is pending
        resolve(32'h104, 3'd3, 32'd0, 32'd0, 16'h0002, 32'h0);
        chk("ar_pre", 32'(bif.redirectValid), 32'd1);
        #2 rstN = 1'b0;
        #1;
        chk_regs("ar", 1'b0, 32'h0, 1'b0, 0, 0);
        #15 rstN = 1'b1;
        tick();
        chk_pred("ar100", 32'h100, 1'b0, 32'h104);
        chk_pred("ar104", 32'h104, 1'b0, 32'h108);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
